// File: rtl/arb_mux_rr.sv
// arb_mux_rr: N-to-1 round-robin/fixed-priority arbiter into a one-word output register (ports: clk, rst, in_valid/in_data/in_ready per channel, out_valid/out_data/out_sel/out_ready downstream)
module arb_mux_rr #(
  parameter int WIDTH = 4,
  parameter int N = 4,
  parameter bit FIXED_PRIO = 1'b0,
  localparam int SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_sel,
  input  logic                 out_ready
);
  logic [N-1:0]     grant;
  logic [SW-1:0]    sel;
  logic [SW-1:0]    ptr;
  logic [WIDTH-1:0] word;
  logic             found;
  logic             can_load;
  logic             take;
  int               idx;
  always_comb begin
    grant = '0;
    sel   = '0;
    word  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = FIXED_PRIO ? k : (int'(ptr) + k) % N;
      if (!found && in_valid[idx]) begin
        grant[idx] = 1'b1;
        sel        = SW'(idx);
        word       = in_data[idx*WIDTH +: WIDTH];
        found      = 1'b1;
      end
    end
  end
  assign can_load = ~out_valid | out_ready;
  assign in_ready = rst ? '0 : grant & {N{can_load}};
  assign take     = |in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= word;
      out_sel   <= sel;
      ptr       <= (sel == SW'(N-1)) ? '0 : sel + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arb_mux_rr.sv
// tb_arb_mux_rr: directed self-checking bench for arb_mux_rr (round-robin N=4, fixed-priority N=4, round-robin N=3)
module tb_arb_mux_rr;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rr_valid = '0;
  logic [15:0] rr_data = 16'hdcba;
  logic [3:0]  rr_ready;
  logic        rr_ovalid;
  logic [3:0]  rr_odata;
  logic [1:0]  rr_osel;
  logic        rr_oready = 1'b1;
  logic [3:0]  fp_valid = '0;
  logic [15:0] fp_data = 16'h4321;
  logic [3:0]  fp_ready;
  logic        fp_ovalid;
  logic [3:0]  fp_odata;
  logic [1:0]  fp_osel;
  logic [2:0]  n3_valid = '0;
  logic [23:0] n3_data = 24'h332211;
  logic [2:0]  n3_ready;
  logic        n3_ovalid;
  logic [7:0]  n3_odata;
  logic [1:0]  n3_osel;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  arb_mux_rr #(.WIDTH(4), .N(4), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst(rst), .in_valid(rr_valid), .in_data(rr_data), .in_ready(rr_ready),
    .out_valid(rr_ovalid), .out_data(rr_odata), .out_sel(rr_osel), .out_ready(rr_oready));
  arb_mux_rr #(.WIDTH(4), .N(4), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst(rst), .in_valid(fp_valid), .in_data(fp_data), .in_ready(fp_ready),
    .out_valid(fp_ovalid), .out_data(fp_odata), .out_sel(fp_osel), .out_ready(1'b1));
  arb_mux_rr #(.WIDTH(8), .N(3), .FIXED_PRIO(1'b0)) u_n3 (
    .clk(clk), .rst(rst), .in_valid(n3_valid), .in_data(n3_data), .in_ready(n3_ready),
    .out_valid(n3_ovalid), .out_data(n3_odata), .out_sel(n3_osel), .out_ready(1'b1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rr_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, 32'(rr_ovalid), 32'(v));
    chk({tag, ".data"}, 32'(rr_odata), 32'(d));
    chk({tag, ".sel"}, 32'(rr_osel), 32'(s));
  endtask

  initial begin
    logic [3:0] seq_d [5] = '{4'ha, 4'hb, 4'hc, 4'hd, 4'ha};
    logic [7:0] n3_d [5]  = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22};
    rr_valid = 4'b1111;
    step();
    step();
    chk("rst_ready", 32'(rr_ready), 32'h0);
    rr_out("rst", 1'b0, 4'h0, 2'd0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_ready%0d", i), 32'(rr_ready), 32'(4'b0001 << (i % 4)));
      step();
      rr_out($sformatf("rr%0d", i), 1'b1, seq_d[i], 2'(i % 4));
    end
    step();
    rr_out("pre_bp", 1'b1, 4'hb, 2'd1);
    rr_oready = 1'b0;
    #1;
    chk("bp_ready0", 32'(rr_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      rr_out($sformatf("bp%0d", i), 1'b1, 4'hb, 2'd1);
      chk($sformatf("bp_ready%0d", i + 1), 32'(rr_ready), 32'h0);
    end
    rr_valid = 4'b0101;
    rr_oready = 1'b1;
    #1;
    chk("ptr_held", 32'(rr_ready), 32'b0100);
    rr_valid = 4'b1111;
    #1;
    chk("bp_release", 32'(rr_ready), 32'b0100);
    step();
    rr_out("bp_after", 1'b1, 4'hc, 2'd2);
    rr_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("ch2_ready%0d", i), 32'(rr_ready), 32'b0100);
      step();
      rr_out($sformatf("ch2_%0d", i), 1'b1, 4'hc, 2'd2);
    end
    rr_valid = 4'b1001;
    #1;
    chk("ch3_ready", 32'(rr_ready), 32'b1000);
    step();
    rr_out("ch3", 1'b1, 4'hd, 2'd3);
    chk("ch0_ready", 32'(rr_ready), 32'b0001);
    step();
    rr_out("ch0", 1'b1, 4'ha, 2'd0);
    rr_valid = 4'b0000;
    #1;
    chk("idle_ready", 32'(rr_ready), 32'h0);
    step();
    rr_out("drain", 1'b0, 4'ha, 2'd0);
    rr_valid = 4'b0010;
    step();
    rr_out("ch1", 1'b1, 4'hb, 2'd1);
    rr_valid = 4'b1111;
    rr_oready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(rr_ready), 32'h0);
    step();
    rr_out("rst_mid", 1'b0, 4'h0, 2'd0);
    rst = 1'b0;
    rr_oready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(rr_ready), 32'b0001);
    step();
    rr_out("post_rst", 1'b1, 4'ha, 2'd0);
    fp_valid = 4'b1010;
    n3_valid = 3'b111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("fp_ready%0d", i), 32'(fp_ready), 32'b0010);
      step();
      chk($sformatf("fp_sel%0d", i), 32'(fp_osel), 32'd1);
      chk($sformatf("fp_data%0d", i), 32'(fp_odata), 32'h2);
      chk($sformatf("fp_valid%0d", i), 32'(fp_ovalid), 32'd1);
      chk($sformatf("n3_sel%0d", i), 32'(n3_osel), 32'(i % 3));
      chk($sformatf("n3_data%0d", i), 32'(n3_odata), 32'(n3_d[i]));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
